// File: rtl/vector_pkg.sv
// Shared definitions for the SIMD vector add/sub/accumulate pipeline.
// Contents: the operation encoding, a lane-slice helper and the parameter legality check.
package vector_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    // LSB position of lane `lane` in a packed vector of `width`-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    function automatic bit params_legal(input int unsigned lanes, input int unsigned width,
                                        input int unsigned stages, input int unsigned saturate);
        return (lanes >= 1) && (width >= 2) && (stages >= 1) && (saturate <= 1);
    endfunction

endpackage

// File: rtl/vector_lane.sv
// One SIMD lane: combinational add/sub/accumulate with optional saturation, plus the lane's
// accumulator register.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   op_i           operation for the beat being offered
//   accept_i       beat accepted this cycle (only then does the accumulator change)
//   a_i, b_i       lane operands
//   res_o, ovf_o   lane result and carry/borrow flag for the offered beat
module vector_lane
    import vector_pkg::*;
#(
    parameter int unsigned Width    = 8,
    parameter bit          Saturate = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  op_t              op_i,
    input  logic             accept_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] res_o,
    output logic             ovf_o
);

    logic [Width-1:0] acc_q, acc_d;
    logic [Width:0]   sum_ext, diff_ext, acc_ext;

    always_comb begin
        sum_ext  = {1'b0, a_i} + {1'b0, b_i};
        // The extra MSB of the difference is the borrow, i.e. a < b.
        diff_ext = {1'b0, a_i} - {1'b0, b_i};
        acc_ext  = {1'b0, acc_q} + {1'b0, a_i};
        res_o    = '0;
        ovf_o    = 1'b0;
        acc_d    = acc_q;
        unique case (op_i)
            OP_ADD: begin
                ovf_o = sum_ext[Width];
                res_o = (Saturate && ovf_o) ? '1 : sum_ext[Width-1:0];
            end
            OP_SUB: begin
                ovf_o = diff_ext[Width];
                res_o = (Saturate && ovf_o) ? '0 : diff_ext[Width-1:0];
            end
            OP_ACC: begin
                ovf_o = acc_ext[Width];
                res_o = (Saturate && ovf_o) ? '1 : acc_ext[Width-1:0];
                // The accumulator keeps the clamped value when saturating.
                if (accept_i) acc_d = res_o;
            end
            OP_CLR: begin
                if (accept_i) acc_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) acc_q <= '0;
        else         acc_q <= acc_d;
    end

endmodule

// File: rtl/vector_addsub_pipe.sv
// Parametrised SIMD vector add/subtract/accumulate pipeline with valid/ready handshake and
// full backpressure. Arithmetic happens on acceptance into stage 1; later stages only move data.
// Ports:
//   clock, reset          clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready never depends on in_valid)
//   op, a, b              operation and packed lane operands (lane i at [i*WIDTH +: WIDTH])
//   out_valid / out_ready output handshake
//   y, ovf                packed lane results and per-lane carry/borrow flags
module vector_addsub_pipe
    import vector_pkg::*;
#(
    parameter int unsigned LANES    = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned SATURATE = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] y,
    output logic [LANES-1:0]       ovf
);

    localparam int unsigned VecW = LANES * WIDTH;

    if (!params_legal(LANES, WIDTH, STAGES, SATURATE)) begin : g_param_err
        $error("vector_addsub_pipe: illegal parameter set");
    end

    op_t                             op_s;
    logic                            accept;
    logic [VecW-1:0]                 res;
    logic [LANES-1:0]                res_ovf;
    logic [STAGES-1:0]               valid_q, valid_d, advance;
    logic [STAGES-1:0][VecW-1:0]     data_q, data_d;
    logic [STAGES-1:0][LANES-1:0]    flag_q, flag_d;

    assign op_s = op_t'(op);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vector_lane #(
            .Width    (WIDTH),
            .Saturate (SATURATE != 0)
        ) u_lane (
            .clk_i    (clock),
            .rst_ni   (reset),
            .op_i     (op_s),
            .accept_i (accept),
            .a_i      (a[lane_lsb(i, WIDTH) +: WIDTH]),
            .b_i      (b[lane_lsb(i, WIDTH) +: WIDTH]),
            .res_o    (res[lane_lsb(i, WIDTH) +: WIDTH]),
            .ovf_o    (res_ovf[i])
        );
    end

    // A stage moves on when it holds a beat and there is room downstream: either the sink
    // takes the output, or some later stage is empty (bubbles collapse in one cycle).
    always_comb begin
        logic path_free;
        path_free = out_ready;
        advance   = '0;
        for (int s = int'(STAGES) - 1; s >= 0; s--) begin
            advance[s] = valid_q[s] && path_free;
            path_free  = path_free || !valid_q[s];
        end
    end

    assign in_ready = reset && (!valid_q[0] || advance[0]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        flag_d  = flag_q;

        valid_d[0] = accept || (valid_q[0] && !advance[0]);
        if (accept) begin
            data_d[0] = res;
            flag_d[0] = res_ovf;
        end

        for (int s = 1; s < int'(STAGES); s++) begin
            valid_d[s] = advance[s-1] || (valid_q[s] && !advance[s]);
            if (advance[s-1]) begin
                data_d[s] = data_q[s-1];
                flag_d[s] = flag_q[s-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            data_q  <= '0;
            flag_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign y         = data_q[STAGES-1];
    assign ovf       = flag_q[STAGES-1];

endmodule

// File: tb/tb_vector_addsub_pipe.sv
// Scoreboard bench: drivers push expected beats on acceptance, a negedge monitor pops and
// compares on every delivery. A second instance covers SATURATE=1.
module tb_vector_addsub_pipe;

    localparam int unsigned LANES  = 4;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;
    localparam int unsigned VW     = LANES * WIDTH;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ACC = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Wrapping instance
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [1:0]    op;
    logic [VW-1:0] a, b, y;
    logic [3:0]    ovf;
    // Saturating instance
    logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [1:0]    s_op;
    logic [VW-1:0] s_a, s_b, s_y;
    logic [3:0]    s_ovf;

    vector_addsub_pipe #(.LANES(LANES), .WIDTH(WIDTH), .STAGES(STAGES), .SATURATE(0)) dut (
        .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
    );

    vector_addsub_pipe #(.LANES(LANES), .WIDTH(WIDTH), .STAGES(STAGES), .SATURATE(1)) dut_sat (
        .clock(clk), .reset(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
        .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready), .y(s_y), .ovf(s_ovf)
    );

    typedef struct {
        logic [VW-1:0] y;
        logic [3:0]    ovf;
        bit            chk_lat;
        int unsigned   cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        sexp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned delivered = 0;
    bit            hold_pend = 1'b0;
    logic [VW-1:0] hold_y;
    logic [3:0]    hold_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pack4(input logic [7:0] l0, input logic [7:0] l1,
                                          input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic mon_step(input bit sat);
        exp_t e;
        logic v, r;
        logic [VW-1:0] yy;
        logic [3:0] oo;
        v  = sat ? s_out_valid : out_valid;
        r  = sat ? s_out_ready : out_ready;
        yy = sat ? s_y : y;
        oo = sat ? s_ovf : ovf;
        if (!sat) begin
            if (hold_pend) begin
                check("stall_y_stable", yy, hold_y);
                check("stall_ovf_stable", oo, hold_ovf);
            end
            hold_pend = v && !r;
            hold_y    = yy;
            hold_ovf  = oo;
        end
        if (v && r) begin
            if ((sat ? sexp_q.size() : exp_q.size()) == 0) begin
                check(sat ? "sat_unexpected_beat" : "unexpected_beat", 1, 0);
            end else begin
                e = sat ? sexp_q.pop_front() : exp_q.pop_front();
                if (!sat) delivered++;
                check(sat ? "sat_y" : "y", yy, e.y);
                check(sat ? "sat_ovf" : "ovf", oo, e.ovf);
                if (e.chk_lat) check("latency", cyc - e.cyc, STAGES);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) hold_pend = 1'b0;
        else begin
            mon_step(1'b0);
            mon_step(1'b1);
        end
    end

    task automatic send(input bit sat, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ey, input logic [3:0] eo,
                        input bit lat);
        exp_t e;
        int n;
        if (sat) begin s_op = o; s_a = av; s_b = bv; s_in_valid = 1'b1; end
        else     begin op = o;   a = av;   b = bv;   in_valid = 1'b1;   end
        n = 0;
        @(negedge clk);
        while (!(sat ? s_in_ready : in_ready) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!(sat ? s_in_ready : in_ready)) begin
            check("accept_wait", 0, 1);
            in_valid = 1'b0;
            s_in_valid = 1'b0;
            return;
        end
        e.y = ey; e.ovf = eo; e.chk_lat = lat; e.cyc = cyc;
        if (sat) sexp_q.push_back(e);
        else     exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sexp_q.size() != 0) && n < 100) begin
            n++;
            @(posedge clk);
        end
        #1;
        check("drain", exp_q.size() + sexp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] av, bv, ey;
        logic [3:0]  eo;
        logic [7:0]  x, z;
        logic [8:0]  s;
        int unsigned base;

        in_valid = 0; op = 0; a = 0; b = 0; out_ready = 1;
        s_in_valid = 0; s_op = 0; s_a = 0; s_b = 0; s_out_ready = 1;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_y", y, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Add with wrap, sub with wrap
        send(0, ADD, pack4(8'h10, 8'h20, 8'h30, 8'hFF), pack4(8'h01, 8'h02, 8'h03, 8'h01),
             pack4(8'h11, 8'h22, 8'h33, 8'h00), 4'b1000, 1);
        send(0, SUB, pack4(8'h05, 8'h00, 8'h80, 8'h10), pack4(8'h03, 8'h01, 8'h01, 8'h10),
             pack4(8'h02, 8'hFF, 8'h7F, 8'h00), 4'b0010, 1);
        drain();

        // Saturation
        send(1, ADD, pack4(8'hFF, 8'h80, 8'h05, 8'h00), pack4(8'h01, 8'h80, 8'h03, 8'h00),
             pack4(8'hFF, 8'hFF, 8'h08, 8'h00), 4'b0011, 1);
        send(1, SUB, pack4(8'h00, 8'h05, 8'h80, 8'hFF), pack4(8'h01, 8'h03, 8'h81, 8'h00),
             pack4(8'h00, 8'h02, 8'h00, 8'hFF), 4'b0101, 1);
        send(1, CLR, 32'hDEADBEEF, 32'h12345678, 32'h0, 4'b0000, 1);
        send(1, ACC, 32'hF0F0F0F0, 32'h0, 32'hF0F0F0F0, 4'b0000, 1);
        send(1, ACC, 32'hF0F0F0F0, 32'h0, 32'hFFFFFFFF, 4'b1111, 1);
        send(1, ACC, pack4(8'h01, 8'h00, 8'h01, 8'h00), 32'h0, 32'hFFFFFFFF, 4'b0101, 1);
        drain();

        // Accumulate with idle gaps; b must be ignored
        send(0, CLR, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h0, 4'b0000, 1);
        send(0, ACC, 32'h05050505, 32'hFFFFFFFF, 32'h05050505, 4'b0000, 1);
        idle(4);
        send(0, ACC, 32'h05050505, 32'hFFFFFFFF, 32'h0A0A0A0A, 4'b0000, 1);
        idle(4);
        send(0, ACC, 32'h05050505, 32'hFFFFFFFF, 32'h0F0F0F0F, 4'b0000, 1);
        drain();
        out_ready = 0;
        idle(4);
        out_ready = 1;
        send(0, ACC, pack4(8'hF5, 8'hF1, 8'h01, 8'h00), 32'h0,
             pack4(8'h04, 8'h00, 8'h10, 8'h0F), 4'b0011, 1);
        drain();

        // Backpressure: two beats absorbed, third held while in_valid stays high
        out_ready = 0;
        send(0, ACC, 32'h01010101, 32'h0, pack4(8'h05, 8'h01, 8'h11, 8'h10), 4'b0000, 0);
        send(0, ACC, 32'h01010101, 32'h0, pack4(8'h06, 8'h02, 8'h12, 8'h11), 4'b0000, 0);
        op = ACC; a = 32'h01010101; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1 out_ready = 1;
        send(0, ACC, 32'h01010101, 32'h0, pack4(8'h07, 8'h03, 8'h13, 8'h12), 4'b0000, 0);
        drain();

        // Reset mid-flight
        out_ready = 0;
        send(0, ACC, 32'h01010101, 32'h0, pack4(8'h08, 8'h04, 8'h14, 8'h13), 4'b0000, 0);
        send(0, ACC, 32'h01010101, 32'h0, pack4(8'h09, 8'h05, 8'h15, 8'h14), 4'b0000, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_y", y, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_in_ready", in_ready, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1;
        idle(1);
        send(0, ACC, 32'h01010101, 32'h0, 32'h01010101, 4'b0000, 1);
        drain();

        // Streaming: 16 back-to-back adds against a lane-wise reference model
        base = delivered;
        for (int k = 0; k < 16; k++) begin
            for (int l = 0; l < 4; l++) begin
                x = 8'(k * 37 + l * 71 + 200);
                z = 8'(k * 53 + l * 29);
                s = {1'b0, x} + {1'b0, z};
                av[l*8 +: 8] = x;
                bv[l*8 +: 8] = z;
                ey[l*8 +: 8] = s[7:0];
                eo[l]        = s[8];
            end
            send(0, ADD, av, bv, ey, eo, 1);
        end
        drain();
        check("stream_count", delivered - base, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
